// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision adder front end.
// Holds the alignment FSM states and the hidden-bit rule shared by the alignment stage.
package fp_pkg;

  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int SIG_W     = FRAC_W + 1;
  localparam int SHIFT_SAT = 24;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ALIGN,
    ADD,
    DONE
  } state_t;

  // Zero and denormal operands carry an implicit leading 0 instead of 1.
  function automatic logic hidden_bit(input logic [EXP_W-1:0] exp);
    return |exp;
  endfunction

endpackage

// File: rtl/adder.sv
// Generic W-bit adder with carry-in.
// The caller widens operands when the carry out must be kept.
module adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  assign sum = a + b + {{(W-1){1'b0}}, cin};

endmodule

// File: rtl/fp_align_shifter.sv
// Iterative right shifter for significand alignment: one bit per enabled cycle.
// Dropped bits are discarded with no sticky bit; busy stays high while shifts remain.
module fp_align_shifter #(
  parameter int SIG_W = 24,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SIG_W-1:0] load_val,
  input  logic [CNT_W-1:0] load_cnt,
  input  logic             en,
  output logic [SIG_W-1:0] value,
  output logic             busy
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
      cnt   <= '0;
    end else if (load) begin
      value <= load_val;
      cnt   <= load_cnt;
    end else if (en && busy) begin
      value <= value >> 1;
      cnt   <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/fp_align_add_unit.sv
// Exponent compare, significand alignment and magnitude add ahead of the normaliser.
// Produces the raw 25-bit significand sum and the larger exponent behind valid/ready.
module fp_align_add_unit #(
  parameter int EXP_W     = 8,
  parameter int FRAC_W    = 23,
  parameter int SHIFT_SAT = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+FRAC_W:0]   a,
  input  logic [EXP_W+FRAC_W:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FRAC_W+1:0]       mantissa,
  output logic [EXP_W:0]          fexp
);

  import fp_pkg::*;

  localparam int M_W = FRAC_W + 1;
  localparam int CNT_W = $clog2(SHIFT_SAT);
  localparam logic [EXP_W-1:0] SAT_LIM = EXP_W'(SHIFT_SAT);

  state_t state, state_nx;

  logic [EXP_W+FRAC_W-1:0] a_q, b_q;
  logic [EXP_W-1:0]        ea, eb, e_big, diff, e_q;
  logic [M_W-1:0]          ma, mb, m_big, m_sml, m_a, sh_val;
  logic                    swap, sat, sh_busy;
  logic [CNT_W-1:0]        ld_cnt;
  logic [M_W:0]            sum;
  logic                    unused_sign;

  // Magnitude-only addition: the normaliser forces the result sign to 0.
  assign unused_sign = a[EXP_W+FRAC_W] ^ b[EXP_W+FRAC_W];

  assign ea = a_q[EXP_W+FRAC_W-1:FRAC_W];
  assign eb = b_q[EXP_W+FRAC_W-1:FRAC_W];
  assign ma = {hidden_bit(ea), a_q[FRAC_W-1:0]};
  assign mb = {hidden_bit(eb), b_q[FRAC_W-1:0]};

  // Equal exponents keep the original operand order.
  assign swap   = (eb > ea);
  assign e_big  = swap ? eb : ea;
  assign m_big  = swap ? mb : ma;
  assign m_sml  = swap ? ma : mb;
  assign diff   = swap ? (eb - ea) : (ea - eb);
  assign sat    = (diff >= SAT_LIM);
  assign ld_cnt = sat ? '0 : diff[CNT_W-1:0];

  fp_align_shifter #(
    .SIG_W(M_W),
    .CNT_W(CNT_W)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (state == LOAD),
    .load_val(sat ? '0 : m_sml),
    .load_cnt(ld_cnt),
    .en      (state == ALIGN),
    .value   (sh_val),
    .busy    (sh_busy)
  );

  adder #(.W(M_W + 1)) u_add (
    .a  ({1'b0, m_a}),
    .b  ({1'b0, sh_val}),
    .cin(1'b0),
    .sum(sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = LOAD;
      LOAD:    state_nx = ALIGN;
      ALIGN:   if (!sh_busy) state_nx = ADD;
      ADD:     state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      m_a      <= '0;
      e_q      <= '0;
      mantissa <= '0;
      fexp     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= a[EXP_W+FRAC_W-1:0];
          b_q <= b[EXP_W+FRAC_W-1:0];
        end
        LOAD: begin
          m_a <= m_big;
          e_q <= e_big;
        end
        ADD: begin
          mantissa <= sum;
          fexp     <= {1'b0, e_q};
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_fp_align_add_unit.sv
// Randomised self-checking bench for fp_align_add_unit against an arithmetic model.
// Covers directed cases, backpressure, mid-operation reset and random operand pairs.
module tb_fp_align_add_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] mantissa;
  logic [8:0]  fexp;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fp_align_add_unit dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mantissa (mantissa),
    .fexp     (fexp)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: pick larger exponent, shift smaller significand by the difference.
  task automatic model(input logic [31:0] x, input logic [31:0] y,
                       output logic [24:0] m, output logic [8:0] e, output int lat);
    int ex, ey, d;
    longint sx, sy;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    sx = longint'(x[22:0]) + ((ex != 0) ? 64'd8388608 : 64'd0);
    sy = longint'(y[22:0]) + ((ey != 0) ? 64'd8388608 : 64'd0);
    if (ey > ex) begin
      d = ey - ex;
      e = 9'(ey);
      m = 25'(sy + ((d >= 24) ? 0 : (sx >> d)));
    end else begin
      d = ex - ey;
      e = 9'(ex);
      m = 25'(sx + ((d >= 24) ? 0 : (sy >> d)));
    end
    lat = 3 + ((d >= 24) ? 0 : d);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check({tag, "_idle_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Issues one operation and checks latency and result; leaves the DUT in DONE.
  task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b);
    logic [24:0] em;
    logic [8:0]  ee;
    int el, lat;
    model(op_a, op_b, em, ee, el);
    wait_idle(tag);
    a = op_a;
    b = op_b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(el));
    check({tag, "_mantissa"}, 32'(mantissa), 32'(em));
    check({tag, "_fexp"}, 32'(fexp), 32'(ee));
    check({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_cleared"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [24:0] held_m;
    logic [8:0]  held_e;
    int ea, eb;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_mantissa", 32'(mantissa), 32'd0);
    check("reset_fexp", 32'(fexp), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("eq_exp", 32'h3F80_0000, 32'h3F80_0000);
    check("eq_exp_abs_m", 32'(mantissa), 32'h0100_0000);
    release_out("eq_exp");
    run_op("diff1", 32'h3F80_0000, 32'h3F00_0000);
    check("diff1_abs_m", 32'(mantissa), 32'h00C0_0000);
    release_out("diff1");
    run_op("swap", 32'h3F00_0000, 32'h3F80_0000);
    check("swap_abs_m", 32'(mantissa), 32'h00C0_0000);
    check("swap_abs_e", 32'(fexp), 32'h07F);
    release_out("swap");
    run_op("sat24", 32'h4B80_0000, 32'h3F80_0000);
    check("sat24_abs_m", 32'(mantissa), 32'h0080_0000);
    check("sat24_abs_e", 32'(fexp), 32'h097);
    release_out("sat24");
    run_op("diff23", 32'h4B00_0000, 32'h3F80_0001);
    release_out("diff23");
    run_op("zeros", 32'h8000_0000, 32'h0000_0000);
    check("zeros_abs_m", 32'(mantissa), 32'h0);
    release_out("zeros");
    run_op("signs", 32'hBF80_0000, 32'h3F80_0000);
    release_out("signs");
    run_op("denorm", 32'h007F_FFFF, 32'h0000_0001);
    release_out("denorm");

    // Backpressure: result must hold while in_valid pulses are ignored.
    run_op("bp", 32'h3F80_0000, 32'h3F80_0000);
    held_m = mantissa;
    held_e = fexp;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = 32'h4000_0000;
      b = 32'h3E00_0000;
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_mantissa", 32'(mantissa), 32'h0100_0000);
      check("bp_fexp", 32'(fexp), 32'h07F);
    end
    in_valid = 1'b0;
    release_out("bp");
    @(posedge clk); #1;
    check("bp_idle_stays", 32'(in_ready), 32'd1);
    check("bp_m_stable", 32'(mantissa), 32'(held_m));
    check("bp_e_stable", 32'(fexp), 32'(held_e));

    // Reset during ALIGN with a 10-position shift pending.
    wait_idle("rst");
    a = 32'h3F80_0000;
    b = 32'h3A80_0000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_busy", 32'(out_valid | in_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_mantissa", 32'(mantissa), 32'd0);
    check("rst_mid_fexp", 32'(fexp), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op("post_rst", 32'h3F80_0000, 32'h3F80_0000);
    release_out("post_rst");

    // Random operands, biased toward interesting exponent relationships.
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = $urandom;
      ea = int'(ra[30:23]);
      case ($urandom_range(0, 3))
        0: ;
        1: begin
          eb = ea + int'($urandom_range(0, 60)) - 30;
          if (eb < 0) eb = 0;
          if (eb > 255) eb = 255;
          rb[30:23] = 8'(eb);
        end
        2: rb[30:23] = 8'h00;
        default: rb[30:23] = ra[30:23];
      endcase
      if ($urandom_range(0, 1) == 1) begin
        run_op("rand", ra, rb);
      end else begin
        run_op("rand", rb, ra);
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        check("rand_hold", 32'(out_valid), 32'd1);
      end
      release_out("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp_align_add_unit.md
Name: fp_align_add_unit

Overview:
- Multi-cycle stage directly upstream of the mantissa normaliser in the single-precision FP adder datapath.
- Accepts two IEEE-754 single-precision operands and selects the larger exponent.
- Aligns the smaller significand with an iterative one-bit-per-cycle right shifter, then adds the two significands.
- Delivers the raw 25-bit sum and 9-bit exponent that the normaliser consumes, behind a valid/ready handshake.

Parameters:
- EXP_W, 8, exponent field width.
- FRAC_W, 23, fraction field width.
- SHIFT_SAT, 24, alignment distance at or above which the smaller significand is forced to zero.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands a and b are valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- a  in  32  operand A, IEEE-754 single.
- b  in  32  operand B, IEEE-754 single.
- out_valid  out  1  mantissa/fexp are valid; held until accepted.
- out_ready  in  1  downstream accepts the result.
- mantissa  out  25  {carry, hidden, fraction[22:0]} sum; feeds the normaliser mantissa input.
- fexp  out  9  {1'b0, larger exponent}; feeds the normaliser fexp input.

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, mantissa=0, fexp=0, all internal registers cleared. Reset mid-operation abandons the current operation with no output.
- Sign bits of a and b are ignored: magnitude addition only, since the normaliser forces sign 0.
- Hidden bit is 1 if the exponent field is non-zero, and 0 if it is zero (zero/denormal operand).
- IDLE: in_ready=1. If in_valid=1 at a rising edge, capture a and b and go to LOAD.
- LOAD (1 cycle):
  - If eB > eA, swap so that A holds the larger exponent. On equal exponents, keep the original order.
  - diff = eA - eB (8-bit, unsigned).
  - mA = {hA, fracA}, 24 bits; mB = {hB, fracB}, 24 bits.
  - If diff >= SHIFT_SAT, set mB = 0 and count = 0; otherwise count = diff.
  - Next state: ALIGN.
- ALIGN:
  - If count != 0: mB <= mB >> 1 (zero fill, discarded bits dropped, no sticky bit), count <= count - 1.
  - If count == 0: go to ADD.
- ADD: mantissa <= {1'b0,mA} + {1'b0,mB}, 25-bit result with no overflow loss; fexp <= {1'b0, eA}. Next state: DONE.
- DONE:
  - out_valid=1; mantissa and fexp held stable.
  - On out_valid & out_ready, go to IDLE with out_valid=0 in the next cycle.
  - in_ready=0, so new operands are never accepted in the same cycle as result acceptance.
- Latency: out_valid rises 3 + d cycles after the accept edge, where d = diff if diff < 24, else d = 0. Maximum is 26 cycles.
- Output changes only on entry to DONE; outputs are otherwise stable.
- in_valid outside IDLE is ignored.
- Both operands zero: mantissa=0, fexp=0.

Decomposition:
- Shared package fp_pkg:
  - state enum {IDLE, LOAD, ALIGN, ADD, DONE};
  - EXP_W, FRAC_W, SIG_W=24, SHIFT_SAT;
  - helper function hidden_bit(exp).
- Mantissa sum uses the existing parameterised adder (adder #(25), cin=0).
- One sub-module is natural: fp_align_shifter, holding the 24-bit shift register and 5-bit down-counter, with load/busy interface.
- Top level holds the FSM, the swap/compare logic and the output registers.

Test Plan:
- Equal exponents, a=0x3F800000, b=0x3F800000 -> mantissa=0x1000000, fexp=0x07F, out_valid 3 cycles after accept.
- a=0x3F800000, b=0x3F000000 (diff 1) -> mantissa=0x0C00000, fexp=0x07F, latency 4.
- Swap case, a=0x3F000000, b=0x3F800000 -> same result as the previous case.
- Saturation, a=0x4B800000, b=0x3F800000 (diff 24) -> mantissa=0x0800000, fexp=0x097, latency 3.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> IDLE next cycle.
- Assert rst during ALIGN with diff=10 -> out_valid=0, mantissa=0, fexp=0 immediately. After release, a new 1.0+1.0 completes correctly.
